max7219_chain_tx: RTL and testbench

Parametrised serial transmitter for a daisy-chain of `N_DEV` MAX7219 LED drivers. It shifts one 16-bit command word per device, MSB first, in a single LOAD (CS) window, with a programmable SPI clock divider. It also offers a broadcast mode that sends one word to every device. It sits between the display controller, which builds the `{addr, data}` command words, and the physical CS/CLK/DIN pins of the chain.

---
 rtl/max7219_chain_tx_if.sv | 23 ++
 rtl/max7219_chain_tx.sv | 133 +++++++++++++
 tb/tb_max7219_chain_tx.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/max7219_chain_tx_if.sv
// Command/status and pin bundle between the display controller and max7219_chain_tx.
interface max7219_chain_tx_if #(
  parameter int unsigned N_DEV = 4
);
  logic                   _str;
  logic                   bcast;
  logic [16*N_DEV-1:0]    frame;
  logic                   CS;
  logic                   CLK;
  logic                   Din;
  logic                   busy;
  logic                   done;

  modport master (
    output _str, bcast, frame,
    input  CS, CLK, Din, busy, done
  );

  modport slave (
    input  _str, bcast, frame,
    output CS, CLK, Din, busy, done
  );
endinterface

// File: rtl/max7219_chain_tx.sv
// Serial transmitter for a daisy-chain of MAX7219 drivers: one 16-bit word per
// device shifted MSB first inside a single CS-low window, optional broadcast.
module max7219_chain_tx #(
  parameter int unsigned N_DEV   = 4,
  parameter int unsigned CLK_DIV = 6
) (
  input  logic                   sys_clk,
  input  logic                   _rst,
  max7219_chain_tx_if.slave      bus
);

  localparam int unsigned SR_W  = 16 * N_DEV;
  localparam int unsigned BIT_W = (SR_W > 1) ? $clog2(SR_W) : 1;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LATCH,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic              cs_q, cs_d;
  logic              clk_q, clk_d;
  logic              din_q, din_d;
  logic              done_q, done_d;
  logic              tick_c;

  assign tick_c = (div_q == DIV_W'(CLK_DIV - 1));

  // State, counters, shift register and pin flops.
  always_ff @(posedge sys_clk or posedge _rst) begin
    if (_rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      cs_q    <= 1'b1;
      clk_q   <= 1'b0;
      din_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      cs_q    <= cs_d;
      clk_q   <= clk_d;
      din_q   <= din_d;
      done_q  <= done_d;
    end
  end

  // Next-state and pin sequencing; every non-IDLE state advances on tick.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    cs_d    = cs_q;
    clk_d   = clk_q;
    din_d   = din_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cs_d  = 1'b1;
        clk_d = 1'b0;
        din_d = 1'b0;
        if (bus._str) begin
          sr_d    = bus.bcast ? {N_DEV{bus.frame[15:0]}} : bus.frame;
          cs_d    = 1'b0;
          din_d   = sr_d[SR_W-1];
          bit_d   = BIT_W'(SR_W - 1);
          state_d = S_SHIFT_LO;
        end
      end
      S_SHIFT_LO: begin
        if (tick_c) begin
          clk_d   = 1'b1;
          state_d = S_SHIFT_HI;
        end
      end
      S_SHIFT_HI: begin
        if (tick_c) begin
          clk_d = 1'b0;
          if (bit_q == '0) begin
            state_d = S_LATCH;
          end else begin
            sr_d    = {sr_q[SR_W-2:0], 1'b0};
            din_d   = sr_q[SR_W-2];
            bit_d   = bit_q - BIT_W'(1);
            state_d = S_SHIFT_LO;
          end
        end
      end
      S_LATCH: begin
        if (tick_c) begin
          cs_d    = 1'b1;
          din_d   = 1'b0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        din_d = 1'b0;
        if (tick_c) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Divider restarts whenever the state changes and is parked in IDLE.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (state_q == S_IDLE || state_d != state_q) begin
      div_d = '0;
    end
  end

  assign bus.CS   = cs_q;
  assign bus.CLK  = clk_q;
  assign bus.Din  = din_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_max7219_chain_tx.sv
// Directed bench for max7219_chain_tx: three instances cover N=1/D=2, N=4/D=1, N=2/D=3.
module tb_max7219_chain_tx;

  logic sys_clk = 1'b0;
  logic rst;

  int n_total = 0;
  int n_bad   = 0;

  always #5 sys_clk = ~sys_clk;

  max7219_chain_tx_if #(.N_DEV(1)) if1 ();
  max7219_chain_tx_if #(.N_DEV(4)) if4 ();
  max7219_chain_tx_if #(.N_DEV(2)) if2 ();

  max7219_chain_tx #(.N_DEV(1), .CLK_DIV(2)) u1 (.sys_clk(sys_clk), ._rst(rst), .bus(if1));
  max7219_chain_tx #(.N_DEV(4), .CLK_DIV(1)) u4 (.sys_clk(sys_clk), ._rst(rst), .bus(if4));
  max7219_chain_tx #(.N_DEV(2), .CLK_DIV(3)) u2 (.sys_clk(sys_clk), ._rst(rst), .bus(if2));

  // Serial receivers: bits captured on each rising CLK edge.
  logic [63:0] rx1, rx4, rx2;
  int          nr1 = 0, nr4 = 0, nr2 = 0;
  logic [15:0] dev [4];

  always @(posedge if1.CLK) begin
    rx1 <= {rx1[62:0], if1.Din};
    nr1 <= nr1 + 1;
  end

  always @(posedge if2.CLK) begin
    rx2 <= {rx2[62:0], if2.Din};
    nr2 <= nr2 + 1;
  end

  // MAX7219 chain model on the 4-device instance: device 0 takes Din.
  always @(posedge if4.CLK) begin
    rx4    <= {rx4[62:0], if4.Din};
    nr4    <= nr4 + 1;
    dev[0] <= {dev[0][14:0], if4.Din};
    dev[1] <= {dev[1][14:0], dev[0][15]};
    dev[2] <= {dev[2][14:0], dev[1][15]};
    dev[3] <= {dev[3][14:0], dev[2][15]};
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic cs_of(input int w);
    case (w)
      1:       return if1.CS;
      4:       return if4.CS;
      default: return if2.CS;
    endcase
  endfunction

  function automatic logic done_of(input int w);
    case (w)
      1:       return if1.done;
      4:       return if4.done;
      default: return if2.done;
    endcase
  endfunction

  // Pulse _str for one sampling edge; returns 1ns after that edge (E0).
  task automatic kick(input int w, input logic bc, input logic [63:0] f);
    case (w)
      1: begin if1.bcast = bc; if1.frame = f[15:0]; if1._str = 1'b1; end
      4: begin if4.bcast = bc; if4.frame = f;       if4._str = 1'b1; end
      default: begin if2.bcast = bc; if2.frame = f[31:0]; if2._str = 1'b1; end
    endcase
    @(posedge sys_clk); #1;
    if1._str = 1'b0;
    if4._str = 1'b0;
    if2._str = 1'b0;
  endtask

  // Observe from the current sample (t=0) until done plus 'extra' cycles.
  task automatic watch(input int w, input int max_cyc, input int extra,
                       output int done_t, output int cs_low, output int n_done);
    done_t = -1;
    cs_low = 0;
    n_done = 0;
    for (int t = 0; t <= max_cyc; t++) begin
      if (t > 0) begin
        @(posedge sys_clk); #1;
      end
      if (cs_of(w) == 1'b0) cs_low++;
      if (done_of(w)) begin
        n_done++;
        if (done_t < 0) done_t = t;
      end
      if (done_t >= 0 && t >= done_t + extra) break;
    end
  endtask

  int done_t, cs_low, n_done, base;
  int d1, d2, rise_t, fall2_t;
  logic prev_cs;

  initial begin
    rst = 1'b1;
    if1._str = 1'b0; if1.bcast = 1'b0; if1.frame = '0;
    if4._str = 1'b0; if4.bcast = 1'b0; if4.frame = '0;
    if2._str = 1'b0; if2.bcast = 1'b0; if2.frame = '0;
    repeat (3) @(posedge sys_clk);
    #1 rst = 1'b0;

    // Reset values
    chk("rst_cs",   64'(if1.CS),   64'd1);
    chk("rst_clk",  64'(if1.CLK),  64'd0);
    chk("rst_din",  64'(if1.Din),  64'd0);
    chk("rst_busy", 64'(if1.busy), 64'd0);
    chk("rst_done", 64'(if1.done), 64'd0);

    // Single device, single word
    @(posedge sys_clk); #1;
    base = nr1;
    kick(1, 1'b0, 64'h0C01);
    chk("t1_cs_fall", 64'(if1.CS),   64'd0);
    chk("t1_busy",    64'(if1.busy), 64'd1);
    watch(1, 200, 3, done_t, cs_low, n_done);
    chk("t1_done_t",  64'(done_t),     64'd68);
    chk("t1_cs_low",  64'(cs_low),     64'd66);
    chk("t1_rises",   64'(nr1 - base), 64'd16);
    chk("t1_bits",    64'(rx1[15:0]),  64'h0C01);
    chk("t1_ndone",   64'(n_done),     64'd1);
    chk("t1_idle",    64'(if1.busy),   64'd0);

    // Chain ordering
    base = nr4;
    kick(4, 1'b0, 64'h0144_0133_0122_0111);
    watch(4, 300, 2, done_t, cs_low, n_done);
    chk("t2_done_t", 64'(done_t),     64'd130);
    chk("t2_cs_low", 64'(cs_low),     64'd129);
    chk("t2_rises",  64'(nr4 - base), 64'd64);
    chk("t2_bits",   rx4,             64'h0144_0133_0122_0111);
    chk("t2_dev0",   64'(dev[0]),     64'h0111);
    chk("t2_dev3",   64'(dev[3]),     64'h0144);

    // Broadcast
    base = nr4;
    kick(4, 1'b1, 64'hFFFF_FFFF_FFFF_0A0F);
    watch(4, 300, 2, done_t, cs_low, n_done);
    chk("t3_rises", 64'(nr4 - base), 64'd64);
    chk("t3_bits",  rx4,             64'h0A0F_0A0F_0A0F_0A0F);
    chk("t3_dev0",  64'(dev[0]),     64'h0A0F);
    chk("t3_dev1",  64'(dev[1]),     64'h0A0F);
    chk("t3_dev2",  64'(dev[2]),     64'h0A0F);
    chk("t3_dev3",  64'(dev[3]),     64'h0A0F);

    // Busy lockout: second request sampled at E0+10
    @(posedge sys_clk); #1;
    base = nr1;
    kick(1, 1'b0, 64'h0C01);
    repeat (9) begin @(posedge sys_clk); #1; end
    if1.frame = 16'hA5A5;
    if1._str  = 1'b1;
    @(posedge sys_clk); #1;
    if1._str  = 1'b0;
    watch(1, 200, 10, done_t, cs_low, n_done);
    chk("t4_done_t", 64'(done_t),     64'd58);
    chk("t4_ndone",  64'(n_done),     64'd1);
    chk("t4_rises",  64'(nr1 - base), 64'd16);
    chk("t4_bits",   64'(rx1[15:0]),  64'h0C01);
    chk("t4_idle",   64'(if1.busy),   64'd0);

    // Async reset during bit 5 while CLK is high
    @(posedge sys_clk); #1;
    kick(1, 1'b0, 64'h0C01);
    repeat (22) begin @(posedge sys_clk); #1; end
    chk("t5_pre_clk", 64'(if1.CLK), 64'd1);
    chk("t5_pre_din", 64'(if1.Din), 64'd1);
    chk("t5_pre_cs",  64'(if1.CS),  64'd0);
    #2 rst = 1'b1;
    #1;
    chk("t5_cs",   64'(if1.CS),   64'd1);
    chk("t5_clk",  64'(if1.CLK),  64'd0);
    chk("t5_din",  64'(if1.Din),  64'd0);
    chk("t5_busy", 64'(if1.busy), 64'd0);
    #10 rst = 1'b0;
    @(posedge sys_clk); #1;
    base = nr1;
    kick(1, 1'b0, 64'h0B07);
    watch(1, 200, 2, done_t, cs_low, n_done);
    chk("t5_done_t", 64'(done_t),     64'd68);
    chk("t5_rises",  64'(nr1 - base), 64'd16);
    chk("t5_bits",   64'(rx1[15:0]),  64'h0B07);

    // Back-to-back with _str held high
    @(posedge sys_clk); #1;
    base    = nr2;
    d1      = -1;
    d2      = -1;
    rise_t  = -1;
    fall2_t = -1;
    if2.bcast = 1'b0;
    if2.frame = 32'h0C01_0F00;
    if2._str  = 1'b1;
    @(posedge sys_clk); #1;
    if2.frame = 32'h0A05_0907;
    prev_cs   = 1'b0;
    for (int t = 0; t <= 600; t++) begin
      if (t > 0) begin
        @(posedge sys_clk); #1;
      end
      if (if2.CS && !prev_cs && rise_t < 0) rise_t = t;
      if (!if2.CS && prev_cs && fall2_t < 0) begin
        fall2_t  = t;
        if2._str = 1'b0;
      end
      if (if2.done) begin
        if (d1 < 0) d1 = t;
        else if (d2 < 0) d2 = t;
      end
      prev_cs = if2.CS;
      if (d2 >= 0 && t >= d2 + 5) break;
    end
    if2._str = 1'b0;
    chk("t6_done1", 64'(d1),              64'd198);
    chk("t6_rise",  64'(rise_t),          64'd195);
    chk("t6_fall2", 64'(fall2_t),         64'd199);
    chk("t6_gap",   64'(fall2_t - rise_t), 64'd4);
    chk("t6_done2", 64'(d2),              64'd397);
    chk("t6_rises", 64'(nr2 - base),      64'd64);
    chk("t6_bits",  rx2,                  64'h0C01_0F00_0A05_0907);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
